// File: rtl/mips_pkg.sv
// Shared constants and types for the multi-cycle MIPS main control FSM.
// Holds the opcode constants, the alu_op / alu_src_b / pc_source encodings
// and the state enum mc_state_t.
package mips_pkg;

  localparam int unsigned OPW = 6;  // opcode field width
  localparam int unsigned STW = 4;  // state register width

  // Opcodes (instr[31:26])
  localparam logic [OPW-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPW-1:0] OP_J     = 6'b000010;
  localparam logic [OPW-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPW-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPW-1:0] OP_LW    = 6'b100011;
  localparam logic [OPW-1:0] OP_SW    = 6'b101011;

  // alu_op encodings consumed by ALU control
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALU B-operand selects
  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  // PC source selects
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [STW-1:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RTWB   = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } mc_state_t;

endpackage

// File: rtl/mips_mc_control_if.sv
// Control bundle between the main control FSM and the datapath.
// master: the control FSM (samples opcode/mem_ready, drives selects/enables).
// slave : the datapath / memory side.
interface mips_mc_control_if;
  import mips_pkg::*;

  logic [OPW-1:0] opcode;
  logic           mem_ready;
  logic           pc_write;
  logic           pc_write_cond;
  logic           i_or_d;
  logic           mem_read;
  logic           mem_write;
  logic           ir_write;
  logic           mem_to_reg;
  logic           reg_dst;
  logic           reg_write;
  logic           alu_src_a;
  logic [1:0]     alu_src_b;
  logic [1:0]     alu_op;
  logic [1:0]     pc_source;
  logic [STW-1:0] state;
  logic           illegal_op;

  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, state, illegal_op
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, state, illegal_op
  );

endinterface

// File: rtl/mips_mc_control.sv
// Multi-cycle MIPS main control FSM (fetch/decode/execute/memory/writeback).
// Ports: clk, rst_n (synchronous, active-low), bus (mips_mc_control_if.master):
//   opcode/mem_ready in; datapath selects, write enables, alu_op, state and
//   illegal_op out.
// Outputs are a Moore decode of state_q; FETCH/MEMRD/MEMWR qualify by mem_ready.
// Build option: MIPS_MC_ADDI_EN enables the addi path (ADDIEX/ADDIWB).
module mips_mc_control
  import mips_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  mips_mc_control_if.master   bus
);

  mc_state_t state_q, state_d;

  logic           pc_write_c, pc_write_cond_c, i_or_d_c, mem_read_c, mem_write_c;
  logic           ir_write_c, mem_to_reg_c, reg_dst_c, reg_write_c, alu_src_a_c;
  logic           illegal_op_c;
  logic [1:0]     alu_src_b_c, alu_op_c, pc_source_c;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Next-state and output decode
  always_comb begin
    state_d         = state_q;
    pc_write_c      = 1'b0;
    pc_write_cond_c = 1'b0;
    i_or_d_c        = 1'b0;
    mem_read_c      = 1'b0;
    mem_write_c     = 1'b0;
    ir_write_c      = 1'b0;
    mem_to_reg_c    = 1'b0;
    reg_dst_c       = 1'b0;
    reg_write_c     = 1'b0;
    alu_src_a_c     = 1'b0;
    alu_src_b_c     = SRCB_B;
    alu_op_c        = ALUOP_ADD;
    pc_source_c     = PCSRC_ALU;
    illegal_op_c    = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_read_c  = 1'b1;
        alu_src_b_c = SRCB_FOUR;
        ir_write_c  = bus.mem_ready;
        pc_write_c  = bus.mem_ready;
        if (bus.mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        // Branch target precompute while the opcode is dispatched
        alu_src_b_c = SRCB_IMM_SH;
        case (bus.opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
`ifdef MIPS_MC_ADDI_EN
          OP_ADDI:      state_d = S_ADDIEX;
`endif
          default: begin
            illegal_op_c = 1'b1;
            state_d      = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = SRCB_IMM;
        // IR is only rewritten in FETCH, so opcode still names lw or sw here
        state_d = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_read_c = 1'b1;
        i_or_d_c   = 1'b1;
        if (bus.mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write_c  = 1'b1;
        mem_to_reg_c = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEMWR: begin
        mem_write_c = 1'b1;
        i_or_d_c    = 1'b1;
        if (bus.mem_ready) state_d = S_FETCH;
      end
      S_EXEC: begin
        alu_src_a_c = 1'b1;
        alu_op_c    = ALUOP_FUNCT;
        state_d     = S_RTWB;
      end
      S_RTWB: begin
        reg_write_c = 1'b1;
        reg_dst_c   = 1'b1;
        state_d     = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a_c     = 1'b1;
        alu_op_c        = ALUOP_SUB;
        pc_write_cond_c = 1'b1;
        pc_source_c     = PCSRC_ALUOUT;
        state_d         = S_FETCH;
      end
      S_JUMP: begin
        pc_write_c  = 1'b1;
        pc_source_c = PCSRC_JUMP;
        state_d     = S_FETCH;
      end
`ifdef MIPS_MC_ADDI_EN
      S_ADDIEX: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = SRCB_IMM;
        state_d     = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write_c = 1'b1;
        state_d     = S_FETCH;
      end
`endif
      default: state_d = S_FETCH;  // unused encodings: all outputs 0
    endcase

    // No write enable may fire in a reset cycle, whatever state we were in
    if (!rst_n) begin
      pc_write_c      = 1'b0;
      pc_write_cond_c = 1'b0;
      mem_write_c     = 1'b0;
      ir_write_c      = 1'b0;
      reg_write_c     = 1'b0;
    end
  end

  assign bus.pc_write      = pc_write_c;
  assign bus.pc_write_cond = pc_write_cond_c;
  assign bus.i_or_d        = i_or_d_c;
  assign bus.mem_read      = mem_read_c;
  assign bus.mem_write     = mem_write_c;
  assign bus.ir_write      = ir_write_c;
  assign bus.mem_to_reg    = mem_to_reg_c;
  assign bus.reg_dst       = reg_dst_c;
  assign bus.reg_write     = reg_write_c;
  assign bus.alu_src_a     = alu_src_a_c;
  assign bus.alu_src_b     = alu_src_b_c;
  assign bus.alu_op        = alu_op_c;
  assign bus.pc_source     = pc_source_c;
  assign bus.state         = STW'(state_q);
  assign bus.illegal_op    = illegal_op_c;

endmodule
